// File: rtl/reg_file_32x32_if.sv
// Register-file access bundle: two read ports and one write port.
// Latency: carries no state; timing is set entirely by the attached register file.
// Backpressure: none, every write and read is accepted in the cycle it is presented.
interface reg_file_32x32_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  // Requester side: issues addresses and write data, receives read data.
  modport master (
    output rs_addr, rt_addr, wr_addr, wr_data, wr_en,
    input  rs_data, rt_data
  );

  // Register-file side.
  modport slave (
    input  rs_addr, rt_addr, wr_addr, wr_data, wr_en,
    output rs_data, rt_data
  );
endinterface

// File: rtl/reg_file_32x32.sv
// 2**ADDR_W x DATA_W register file, two combinational read ports, one write port, r0 hardwired to 0.
// Latency: reads 0 cycles with write-through bypass; writes land on the next rising edge.
// Backpressure: none; a write presented with wr_en=1 is always taken unless reset is high.
module reg_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  reg_file_32x32_if.slave    rf
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_fire;

  // A write only counts when enabled, out of reset, and not aimed at r0;
  // the same qualifier gates the bypass so a dropped write is never forwarded.
  assign wr_fire = rf.wr_en && !reset && (rf.wr_addr != '0);

  // Storage: reset clears everything and takes priority over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[rf.wr_addr] <= rf.wr_data;
    end
  end

  // Read port A: r0 forced to zero, otherwise forward the in-flight write or read storage.
  always_comb begin
    rf.rs_data = '0;
    if (rf.rs_addr != '0) begin
      if (wr_fire && (rf.wr_addr == rf.rs_addr)) begin
        rf.rs_data = rf.wr_data;
      end else begin
        rf.rs_data = regs[rf.rs_addr];
      end
    end
  end

  // Read port B: identical rule, evaluated independently of port A.
  always_comb begin
    rf.rt_data = '0;
    if (rf.rt_addr != '0) begin
      if (wr_fire && (rf.wr_addr == rf.rt_addr)) begin
        rf.rt_data = rf.wr_data;
      end else begin
        rf.rt_data = regs[rf.rt_addr];
      end
    end
  end
endmodule

// File: tb/tb_reg_file_32x32.sv
// Randomized scoreboard bench for reg_file_32x32 against an array reference model.
// Latency: expected reads are queued per stimulus cycle and checked before the next edge.
// Backpressure: none; the monitor drains the queue every cycle.
module tb_reg_file_32x32;
  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  ra;
    logic [4:0]  rb;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  logic [31:0] model [32];
  bit          model_known;

  reg_file_32x32_if #(.DATA_W(32), .ADDR_W(5)) rf_if ();

  reg_file_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the architectural rules: r0 is zero, a live write
  // to the same register is visible immediately, otherwise the stored value.
  function automatic logic [31:0] expect_read(input logic [4:0] a, input logic rst,
                                              input logic we, input logic [4:0] wa,
                                              input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (!rst && we && (wa == a)) return wd;
    return model[a];
  endfunction

  // One cycle of stimulus: drive at the falling edge, queue expectations, then
  // advance the model at the rising edge.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    rf_if.wr_en   = we;
    rf_if.wr_addr = wa;
    rf_if.wr_data = wd;
    rf_if.rs_addr = ra;
    rf_if.rt_addr = rb;
    if (model_known) begin
      e.rs = expect_read(ra, rst, we, wa, wd);
      e.rt = expect_read(rb, rst, we, wa, wd);
      e.ra = ra;
      e.rb = rb;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_known = 1'b1;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  // Monitor: read data is valid every cycle, sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rf_if.rs_data !== e.rs) begin
          n_fail++;
          $display("FAIL rs_data addr=%0d got=%h want=%h t=%0t", e.ra, rf_if.rs_data, e.rs, $time);
        end
        n_checks++;
        if (rf_if.rt_data !== e.rt) begin
          n_fail++;
          $display("FAIL rt_data addr=%0d got=%h want=%h t=%0t", e.rb, rf_if.rt_data, e.rt, $time);
        end
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    model_known   = 1'b0;
    reset         = 1'b1;
    rf_if.wr_en   = 1'b0;
    rf_if.wr_addr = '0;
    rf_if.wr_data = '0;
    rf_if.rs_addr = '0;
    rf_if.rt_addr = '0;

    // Reset, then sweep every address on both ports.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) step(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));

    // Plain write then read back; neighbour untouched.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);

    // Write to r0 is discarded, same cycle and after the edge.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Dual-port bypass on r19, then stored value after the edge.
    step(1'b0, 1'b1, 5'd19, 32'h00000001, 5'd19, 5'd0);
    step(1'b0, 1'b1, 5'd19, 32'h12345678, 5'd19, 5'd19);
    step(1'b0, 1'b0, 5'd19, 32'h0, 5'd19, 5'd19);

    // Reset beats a concurrent write; bypass suppressed during reset.
    step(1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5);
    step(1'b1, 1'b1, 5'd31, 32'h00000001, 5'd31, 5'd31);
    step(1'b0, 1'b0, 5'd31, 32'h0, 5'd31, 5'd5);

    // Disabled write leaves the register alone.
    step(1'b0, 1'b1, 5'd7, 32'h0BADF00D, 5'd7, 5'd0);
    step(1'b0, 1'b0, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // First write after a mid-sequence reset takes effect on the next edge.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd19);
    step(1'b0, 1'b1, 5'd3, 32'h13579BDF, 5'd3, 5'd7);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd19);

    // Random traffic with occasional resets; reads biased toward the write address.
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic       w;
      logic [4:0] wa;
      logic [4:0] ra;
      logic [4:0] rb;
      r  = ($urandom_range(0, 49) == 0);
      w  = ($urandom_range(0, 2) != 0);
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(r, w, wa, $urandom, ra, rb);
    end

    // Let the monitor drain; a leftover entry means a check never happened.
    repeat (3) @(negedge clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_32x32.md
REG_FILE_32X32 -- requirements
Module: reg_file_32x32

Interface
REQ-001 Parameter DATA_W, default 32, width in bits of each register and of every data port.
REQ-002 Parameter ADDR_W, default 5, address width; register count SHALL be 2**ADDR_W (32 at default).
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 rs_addr  input  ADDR_W  read port A address.
REQ-006 rt_addr  input  ADDR_W  read port B address.
REQ-007 wr_addr  input  ADDR_W  write address, driven by the 5-bit destination-register 2:1 mux output.
REQ-008 wr_data  input  DATA_W  write data.
REQ-009 wr_en  input  1  write enable.
REQ-010 rs_data  output  DATA_W  read port A data.
REQ-011 rt_data  output  DATA_W  read port B data.
REQ-012 The design SHALL use one clock and a synchronous, active-high reset; clock port named clk, reset port named reset.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits each, regs[0..31].
REQ-014 Write: on a rising edge with reset=0, wr_en=1 and wr_addr!=0, regs[wr_addr] SHALL take wr_data; no other register changes.
REQ-015 wr_en=0 SHALL leave all registers unchanged, whatever the values of wr_addr and wr_data.
REQ-016 Register 0 SHALL read as 0 on both ports; writes to address 0 SHALL be discarded with no side effect.
REQ-017 Reads SHALL be combinational: rs_data = regs[rs_addr] and rt_data = regs[rt_addr] in the same cycle, with zero clock latency.
REQ-018 Write-through bypass: if wr_en=1, reset=0, wr_addr!=0 and wr_addr==rs_addr, rs_data SHALL equal wr_data in that cycle (before the edge); same rule for rt_addr/rt_data.
REQ-019 Both ports SHALL bypass at once when rs_addr==rt_addr==wr_addr.
REQ-020 Bypass SHALL be suppressed while reset=1; ports then show current stored contents.
REQ-021 Simultaneous reset=1 and wr_en=1 on one edge: reset SHALL win; the write is dropped.
REQ-022 Both read ports SHALL operate independently and may address the same register in the same cycle.
REQ-023 Outputs SHALL never be X/Z once reset has been applied for one edge, for any in-range address.
REQ-024 No other state, counters or handshakes; write latency is one edge, read latency zero.

Reset
REQ-025 A rising edge with reset=1 SHALL clear all registers to 0 by the end of that edge.
REQ-026 After reset, rs_data and rt_data SHALL be 0 for every address until a subsequent write.
REQ-027 Reset asserted mid-sequence (between writes) SHALL clear all prior writes; the first write after reset deassertion SHALL take effect on the next edge.

Verification
REQ-028 Reset, then sweep rs_addr/rt_addr over 0..31 -> every read returns 32'h0.
REQ-029 Write regs[5]=32'hDEADBEEF (wr_en=1, wr_addr=5'b00101), next cycle rs_addr=5 -> rs_data=32'hDEADBEEF; rt_addr=6 -> 32'h0.
REQ-030 wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF, then read address 0 on both ports -> 32'h0 in the same cycle and after the edge.
REQ-031 Bypass: regs[19]=32'h1; drive wr_en=1, wr_addr=5'b10011, wr_data=32'h12345678, rs_addr=rt_addr=19 -> both ports show 32'h12345678 before the edge; wr_en=0 after the edge -> both still 32'h12345678.
REQ-032 Reset precedence: regs[31]=32'hA5A5A5A5; one edge with reset=1, wr_en=1, wr_addr=31, wr_data=32'h1 -> regs[31] reads 32'h0.
REQ-033 wr_en=0 with wr_addr=7, wr_data=32'hCAFEF00D -> regs[7] keeps its prior value.
